// File: rtl/sha256_pkg.sv
// ============================================================================
// Module      : sha256_pkg
// Description : Shared types and constants for the SHA-256 message packer.
//               Holds the chunk geometry, the packer state encoding and the
//               byte-count type that sizes byte_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

  localparam int SHA_CHUNK_BYTES = 55;
  localparam int SHA_CHUNK_W     = 440;

  typedef enum logic [2:0] {
    PKR_FILL,
    PKR_EMIT,
    PKR_GAP,
    PKR_TERM,
    PKR_WAIT_HASH
  } pkr_state_t;

  // Byte count within one chunk; 6 bits bounds a chunk at 63 bytes.
  typedef logic [5:0] sha_bcnt_t;

endpackage

`default_nettype wire

// File: rtl/sha256_msg_packer.sv
// ============================================================================
// Module      : sha256_msg_packer
// Description : Packs a valid/ready byte stream MSB-first into chunks of up to
//               CHUNK_BYTES bytes for the SHA-256 core. Issues one msg_valid
//               strobe per chunk, then a terminator strobe (byte_valid=0) per
//               message, and optionally waits for hash_done before accepting
//               the next message.
// Ports       : clk, rst_n            - clock, async active-low reset
//               s_valid/s_data/s_keep/s_last/s_ready - byte stream input
//               msg_valid/byte_valid/msg_word        - chunk output to core
//               hash_done             - core finished current message
//               busy                  - message in progress
//               msg_len (option)      - running byte count of the message
// Options     : SHA_PKR_LEN_CNT_EN - adds the 64-bit msg_len output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_packer
  import sha256_pkg::*;
#(
  parameter int CHUNK_BYTES = SHA_CHUNK_BYTES,
  parameter int GAP_CYCLES  = 1,
  parameter int WAIT_DONE   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  input  logic                     s_keep,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     msg_valid,
  output logic [5:0]               byte_valid,
  output logic [CHUNK_BYTES*8-1:0] msg_word,
  input  logic                     hash_done,
`ifdef SHA_PKR_LEN_CNT_EN
  output logic [63:0]              msg_len,
`endif
  output logic                     busy
);

  localparam int        CW      = CHUNK_BYTES * 8;
  localparam int        GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam sha_bcnt_t C_CHUNK = sha_bcnt_t'(CHUNK_BYTES);
  localparam sha_bcnt_t C_ONE   = sha_bcnt_t'(1);

  pkr_state_t       state_q, state_d;
  sha_bcnt_t        count_q, count_d;
  logic [CW-1:0]    buf_q, buf_d;
  logic             last_q, last_d;       // final beat of the message seen
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             s_ready_q;
  logic             busy_q;
  logic             accept;
  logic [CW-1:0]    byte_at_top;

  assign accept      = s_valid && s_ready_q;
  // Incoming byte placed in slot 0; shifted right into slot count on write.
  assign byte_at_top = {s_data, {(CW-8){1'b0}}};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    last_d  = last_q;
    gap_d   = gap_q;
    case (state_q)
      PKR_FILL: begin
        if (accept) begin
          if (s_keep) begin
            // Buffer is zero beyond count, so OR-ing in the byte is a write.
            buf_d   = buf_q | (byte_at_top >> {count_q, 3'b000});
            count_d = count_q + C_ONE;
          end
          if (s_last) begin
            last_d  = 1'b1;
            state_d = (count_d != '0) ? PKR_EMIT : PKR_TERM;
          end else if (count_d == C_CHUNK) begin
            state_d = PKR_EMIT;
          end
        end
      end
      PKR_EMIT: begin
        buf_d   = '0;
        count_d = '0;
        gap_d   = '0;
        state_d = PKR_GAP;
      end
      PKR_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = last_q ? PKR_TERM : PKR_FILL;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      PKR_TERM: begin
        last_d  = 1'b0;
        gap_d   = '0;
        state_d = (WAIT_DONE != 0) ? PKR_WAIT_HASH : PKR_GAP;
      end
      PKR_WAIT_HASH: begin
        if (hash_done) state_d = PKR_FILL;
      end
      default: state_d = PKR_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PKR_FILL;
      count_q   <= '0;
      buf_q     <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      buf_q     <= buf_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      // Registered decode of the next state keeps s_valid off the s_ready path.
      s_ready_q <= (state_d == PKR_FILL);
      busy_q    <= (state_d != PKR_FILL) || (count_d != '0);
    end
  end

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign msg_valid  = (state_q == PKR_EMIT) || (state_q == PKR_TERM);
  assign byte_valid = (state_q == PKR_EMIT) ? count_q : '0;
  assign msg_word   = (state_q == PKR_EMIT) ? buf_q : '0;

`ifdef SHA_PKR_LEN_CNT_EN
  logic [63:0] len_q, len_d;
  logic        new_msg_q, new_msg_d;   // next accepted beat starts a message

  always_comb begin
    len_d     = len_q;
    new_msg_d = new_msg_q;
    if (state_q == PKR_TERM) begin
      new_msg_d = 1'b1;
    end else if (accept) begin
      if (new_msg_q) begin
        len_d     = s_keep ? 64'd1 : 64'd0;
        new_msg_d = 1'b0;
      end else if (s_keep && (len_q != '1)) begin
        len_d = len_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      new_msg_q <= 1'b1;
    end else begin
      len_q     <= len_d;
      new_msg_q <= new_msg_d;
    end
  end

  assign msg_len = len_q;
`endif

endmodule

`default_nettype wire
